// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit/receive blocks.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        LINE_IDLE = 1'b1;
  localparam logic        START_LVL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and ticks bit_end on the last one.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start, 8 data bits LSB first, optional even parity, stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (Clk),
    .rst    (Reset),
    .restart(state_q == IDLE),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (send) begin
          state_d  = START;
          shift_d  = data_in;
          parity_d = ^data_in;
          idx_d    = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state about to be entered.
    case (state_d)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (C=4 parity, C=4 no parity, C=1 parity) share stimulus.
module tb_serial_tx;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] data_in;
  logic       send;
  logic [2:0] tx, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;

  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .data_in(data_in), .send(send),
    .tx_out(tx[0]), .busy(busy[0]), .done(done[0]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .data_in(data_in), .send(send),
    .tx_out(tx[1]), .busy(busy[1]), .done(done[1]));
  serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .data_in(data_in), .send(send),
    .tx_out(tx[2]), .busy(busy[2]), .done(done[2]));

  function automatic int cpb(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic int npar(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input int d, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d got=%b want=%b", nm, d, cyc, got, want);
    end
  endtask

  // Reference model: each DUT holds at most one frame, described by start cycle and bit list.
  bit          act[3];
  int          fstart[3];
  logic [10:0] fb[3];

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int  fend;
      bit  prev_busy;
      fend      = fstart[d] + (10 + npar(d)) * cpb(d) - 1;
      prev_busy = act[d] && (cyc - 1 >= fstart[d]) && (cyc - 1 <= fend);
      if (Reset) begin
        act[d] = 1'b0;
      end else if (!prev_busy && send) begin
        act[d]    = 1'b1;
        fstart[d] = cyc;
        if (npar(d) == 1) fb[d] = {1'b1, ^data_in, data_in, 1'b0};
        else              fb[d] = {1'b0, 1'b1, data_in, 1'b0};
      end
    end
  endtask

  task automatic model_check();
    for (int d = 0; d < 3; d++) begin
      int   fend;
      logic etx, ebusy, edone;
      fend = fstart[d] + (10 + npar(d)) * cpb(d) - 1;
      if (act[d] && cyc >= fstart[d] && cyc <= fend) begin
        etx   = fb[d][(cyc - fstart[d]) / cpb(d)];
        ebusy = 1'b1;
        edone = 1'b0;
      end else begin
        etx   = 1'b1;
        ebusy = 1'b0;
        edone = act[d] && (cyc == fend + 1);
      end
      chk("model_tx", d, tx[d], etx);
      chk("model_busy", d, busy[d], ebusy);
      chk("model_done", d, done[d], edone);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    cyc++;
    model_edge();
    @(negedge Clk);
  endtask

  task automatic check_idle(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_tx"}, d, tx[d], 1'b1);
      chk({nm, "_busy"}, d, busy[d], 1'b0);
      chk({nm, "_done"}, d, done[d], 1'b0);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] f_par;    // time order from bit 0: start, d0..d7, parity, stop
    logic [9:0]  f_nopar;  // start, d0..d7, stop
  } vec_t;

  vec_t vecs[6];

  task automatic dir_check(input int v, input int t);
    for (int d = 0; d < 3; d++) begin
      int   c, n;
      logic etx, ebusy, edone;
      c = cpb(d);
      n = 10 + npar(d);
      if (t <= n * c) begin
        etx   = (npar(d) == 1) ? vecs[v].f_par[(t - 1) / c] : vecs[v].f_nopar[(t - 1) / c];
        ebusy = 1'b1;
        edone = 1'b0;
      end else begin
        etx   = 1'b1;
        ebusy = 1'b0;
        edone = (t == n * c + 1);
      end
      chk("vec_tx", d, tx[d], etx);
      chk("vec_busy", d, busy[d], ebusy);
      chk("vec_done", d, done[d], edone);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, f_par: 11'b1_0_10100101_0, f_nopar: 10'b1_10100101_0};
    vecs[1] = '{data: 8'h07, f_par: 11'b1_1_00000111_0, f_nopar: 10'b1_00000111_0};
    vecs[2] = '{data: 8'h81, f_par: 11'b1_0_10000001_0, f_nopar: 10'b1_10000001_0};
    vecs[3] = '{data: 8'h3C, f_par: 11'b1_0_00111100_0, f_nopar: 10'b1_00111100_0};
    vecs[4] = '{data: 8'h01, f_par: 11'b1_1_00000001_0, f_nopar: 10'b1_00000001_0};
    vecs[5] = '{data: 8'hFE, f_par: 11'b1_1_11111110_0, f_nopar: 10'b1_11111110_0};
    for (int d = 0; d < 3; d++) begin
      act[d]    = 1'b0;
      fstart[d] = 0;
      fb[d]     = '1;
    end

    Reset   = 1'b1;
    send    = 1'b0;
    data_in = 8'h00;
    #1;
    check_idle("reset");
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Directed frames; an 0xFF request mid-frame must be ignored and not queued.
    for (int v = 0; v < 6; v++) begin
      data_in = vecs[v].data;
      send    = 1'b1;
      tick();
      for (int t = 1; t <= 50; t++) begin
        dir_check(v, t);
        send    = (t == 9);
        data_in = (t == 9) ? 8'hFF : 8'($urandom);
        tick();
      end
    end
    send = 1'b0;

    // Back-to-back: send held high, second byte accepted in the done cycle.
    data_in = 8'h3C;
    send    = 1'b1;
    tick();
    data_in = 8'hC3;
    for (int t = 1; t <= 120; t++) begin
      model_check();
      if (t == 44) chk("b2b_stop", 0, tx[0], 1'b1);
      if (t == 45) chk("b2b_done", 0, done[0], 1'b1);
      if (t == 46) chk("b2b_start", 0, tx[0], 1'b0);
      if (t == 50) chk("b2b_d0", 0, tx[0], 1'b1);
      if (t == 60) send = 1'b0;
      tick();
    end

    // Asynchronous reset during data bit 3 of the C=4 instances.
    data_in = 8'hA5;
    send    = 1'b1;
    tick();
    send = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      model_check();
      tick();
    end
    model_check();
    #2;
    Reset = 1'b1;
    #1;
    check_idle("async_rst");
    for (int d = 0; d < 3; d++) act[d] = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      model_check();
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      model_check();
      send    = ($urandom_range(0, 5) == 0);
      data_in = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
